// File: rtl/serial_adder.sv
// Digit-serial adder: adds two WIDTH-bit operands DIGIT bits per clock through one slice.
// Latency: done pulses N=WIDTH/DIGIT clocks after the accepted start edge; one op per N+1 clocks.
// Backpressure: start is sampled only while idle; start during busy (including the last edge) is dropped.
//
// Ports:
//   i_clk, i_rst      : clock; synchronous active-high reset (priority over everything)
//   i_start           : request, accepted only when o_busy=0
//   i_a, i_b          : operands, captured on the accepted start edge
//   i_sub             : present only with SERIAL_ADDER_SUB_EN; 1 selects a-b
//   o_busy            : high while digits are being processed
//   o_done            : one-cycle pulse; o_sum/o_cout valid from this cycle
//   o_sum, o_cout     : registered result and carry out, held until the next done
//
// Optional feature macro: SERIAL_ADDER_SUB_EN (adds i_sub; subtraction as a + ~b + 1).
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             i_sub,
`endif
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("serial_adder: WIDTH must be >= 1 and DIGIT must divide WIDTH");
    end
  endgenerate

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_done;

  logic             w_sub;
  logic [WIDTH-1:0] w_b_in;
  logic [DIGIT:0]   w_dig;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             w_last;

`ifdef SERIAL_ADDER_SUB_EN
  assign w_sub = i_sub;
`else
  assign w_sub = 1'b0;
`endif

  // Subtraction reuses the adder: B is stored inverted and the carry starts at 1.
  assign w_b_in = w_sub ? ~i_b : i_b;

  // The single DIGIT-bit slice; bit DIGIT is the carry into the next digit.
  assign w_dig = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};

  // Result digits enter from the MSB side so after N shifts digit 0 sits at the LSB.
  generate
    if (N == 1) begin : g_single
      assign w_acc_nxt = w_dig[DIGIT-1:0];
    end else begin : g_multi
      assign w_acc_nxt = {w_dig[DIGIT-1:0], r_acc[WIDTH-1:DIGIT]};
    end
  endgenerate

  assign w_last = (r_cnt == CW'(N - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_a     <= i_a;
            r_b     <= w_b_in;
            r_carry <= w_sub;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        default: begin
          r_carry <= w_dig[DIGIT];
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_acc   <= w_acc_nxt;
          r_cnt   <= r_cnt + CW'(1);
          // Only the completed result is ever published on sum/cout.
          if (w_last) begin
            r_sum   <= w_acc_nxt;
            r_cout  <= w_dig[DIGIT];
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign o_busy = (r_state == S_RUN);
  assign o_done = r_done;
  assign o_sum  = r_sum;
  assign o_cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: four instances (8/1, 8/4, 16/1, 8/2)
// share operand buses; each has its own start and reset. Expected results are
// queued when a start is driven and popped when done is observed.
module tb_serial_adder;

  logic        clk;
  logic [3:0]  start_vec;
  logic [3:0]  rst_vec;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        op_sub;
  int          sel;

  logic        d1_busy, d1_done, d1_cout;
  logic [7:0]  d1_sum;
  logic        d4_busy, d4_done, d4_cout;
  logic [7:0]  d4_sum;
  logic        w16_busy, w16_done, w16_cout;
  logic [15:0] w16_sum;
  logic        d2_busy, d2_done, d2_cout;
  logic [7:0]  d2_sum;

  logic        m_busy, m_done, m_cout;
  logic [15:0] m_sum;

  logic [16:0] exp_q[$];
  int          errors;
  int          checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .i_clk(clk), .i_rst(rst_vec[0]), .i_start(start_vec[0]),
`ifdef SERIAL_ADDER_SUB_EN
    .i_sub(op_sub),
`endif
    .i_a(op_a[7:0]), .i_b(op_b[7:0]),
    .o_busy(d1_busy), .o_done(d1_done), .o_sum(d1_sum), .o_cout(d1_cout)
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .i_clk(clk), .i_rst(rst_vec[1]), .i_start(start_vec[1]),
`ifdef SERIAL_ADDER_SUB_EN
    .i_sub(op_sub),
`endif
    .i_a(op_a[7:0]), .i_b(op_b[7:0]),
    .o_busy(d4_busy), .o_done(d4_done), .o_sum(d4_sum), .o_cout(d4_cout)
  );

  serial_adder #(.WIDTH(16), .DIGIT(1)) u_w16 (
    .i_clk(clk), .i_rst(rst_vec[2]), .i_start(start_vec[2]),
`ifdef SERIAL_ADDER_SUB_EN
    .i_sub(op_sub),
`endif
    .i_a(op_a), .i_b(op_b),
    .o_busy(w16_busy), .o_done(w16_done), .o_sum(w16_sum), .o_cout(w16_cout)
  );

  serial_adder #(.WIDTH(8), .DIGIT(2)) u_d2 (
    .i_clk(clk), .i_rst(rst_vec[3]), .i_start(start_vec[3]),
`ifdef SERIAL_ADDER_SUB_EN
    .i_sub(op_sub),
`endif
    .i_a(op_a[7:0]), .i_b(op_b[7:0]),
    .o_busy(d2_busy), .o_done(d2_done), .o_sum(d2_sum), .o_cout(d2_cout)
  );

  always_comb begin
    m_busy = 1'b0;
    m_done = 1'b0;
    m_sum  = '0;
    m_cout = 1'b0;
    case (sel)
      0: begin m_busy = d1_busy;  m_done = d1_done;  m_sum = {8'h00, d1_sum}; m_cout = d1_cout;  end
      1: begin m_busy = d4_busy;  m_done = d4_done;  m_sum = {8'h00, d4_sum}; m_cout = d4_cout;  end
      2: begin m_busy = w16_busy; m_done = w16_done; m_sum = w16_sum;         m_cout = w16_cout; end
      default: begin m_busy = d2_busy; m_done = d2_done; m_sum = {8'h00, d2_sum}; m_cout = d2_cout; end
    endcase
  end

  // Reference: {cout, sum}. Subtraction: sum=(a-b) mod 2^w, cout=1 when a>=b.
  function automatic logic [16:0] model(input int w, input logic [15:0] a,
                                        input logic [15:0] b, input logic s);
    logic [16:0] t;
    logic [15:0] m;
    m = (w == 16) ? 16'hFFFF : 16'h00FF;
    if (s) begin
      t[15:0] = (a - b) & m;
      t[16]   = ((a & m) >= (b & m));
    end else begin
      t = {1'b0, a & m} + {1'b0, b & m};
      if (w == 8) t = {t[8], 8'h00, t[7:0]};
    end
    return t;
  endfunction

  function automatic logic [16:0] pop_exp();
    if (exp_q.size() == 0) return 17'bx;
    return exp_q.pop_front();
  endfunction

  // Drive one start request (held until the observer drops it) and queue its expectation.
  task automatic launch(input int idx, input logic [15:0] a, input logic [15:0] b, input logic s);
    @(negedge clk);
    sel            = idx;
    op_a           = a;
    op_b           = b;
    op_sub         = s;
    start_vec      = '0;
    start_vec[idx] = 1'b1;
    exp_q.push_back(model((idx == 2) ? 16 : 8, a, b, s));
  endtask

  // Samples the selected DUT at the negedge after each posedge (c = edges since start).
  task automatic obs(input int ncyc, input int drop_at, input int rst_at, input logic [16:0] hold,
                     output int done_at, output int done2_at, output int ndone,
                     output int busy_cnt, output int hold_bad,
                     output logic [16:0] res, output logic [16:0] res2);
    done_at = -1; done2_at = -1; ndone = 0; busy_cnt = 0; hold_bad = 0;
    res = 17'bx; res2 = 17'bx;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (m_busy === 1'b1) busy_cnt++;
      if (m_done === 1'b1) begin
        ndone++;
        if (done_at < 0) begin done_at = c; res = {m_cout, m_sum}; end
        else if (done2_at < 0) begin done2_at = c; res2 = {m_cout, m_sum}; end
      end else if (done_at < 0 && {m_cout, m_sum} !== hold) begin
        hold_bad++;
      end
      if (c == drop_at) start_vec = '0;
      if (c == rst_at) rst_vec[sel] = 1'b1;
      if (rst_at >= 0 && c == rst_at + 1) rst_vec = '0;
    end
  endtask

  task automatic test_reset();
    rst_vec = '1;
    repeat (3) @(negedge clk);
    rst_vec = '0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      sel = i;
      #1;
      checks++;
      if (m_busy !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b expected 0", i, m_busy); end
      checks++;
      if (m_done !== 1'b0) begin errors++; $display("FAIL reset_done[%0d]: got %b expected 0", i, m_done); end
      checks++;
      if ({m_cout, m_sum} !== 17'h0) begin errors++; $display("FAIL reset_sum[%0d]: got %h expected 00000", i, {m_cout, m_sum}); end
    end
  endtask

  task automatic test_add_basic();
    int da, d2a, nd, bc, hb; logic [16:0] r, r2, e;
    launch(0, 16'h005A, 16'h003C, 1'b0);
    obs(12, 0, -1, 17'h0, da, d2a, nd, bc, hb, r, r2);
    e = pop_exp();
    checks++; if (da !== 8)  begin errors++; $display("FAIL basic_latency: got %0d expected 8", da); end
    checks++; if (nd !== 1)  begin errors++; $display("FAIL basic_done_count: got %0d expected 1", nd); end
    checks++; if (bc !== 8)  begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 8", bc); end
    checks++; if (hb !== 0)  begin errors++; $display("FAIL basic_sum_hold: got %0d bad cycles expected 0", hb); end
    checks++; if (r !== e)   begin errors++; $display("FAIL basic_result: got %h expected %h", r, e); end
  endtask

  task automatic test_back_to_back();
    int da, d2a, nd, bc, hb; logic [16:0] r, r2, e1, e2;
    launch(0, 16'h00FF, 16'h0001, 1'b0);
    fork
      obs(22, 9, -1, 17'h00096, da, d2a, nd, bc, hb, r, r2);
      begin
        repeat (3) @(negedge clk);
        op_a = 16'h0012;
        op_b = 16'h0034;
        exp_q.push_back(model(8, 16'h0012, 16'h0034, 1'b0));
      end
    join
    e1 = pop_exp();
    e2 = pop_exp();
    checks++; if (r !== e1)   begin errors++; $display("FAIL b2b_first_result: got %h expected %h", r, e1); end
    checks++; if (da !== 8)   begin errors++; $display("FAIL b2b_first_latency: got %0d expected 8", da); end
    checks++; if (d2a !== 17) begin errors++; $display("FAIL b2b_second_done_edge: got %0d expected 17", d2a); end
    checks++; if (r2 !== e2)  begin errors++; $display("FAIL b2b_second_result: got %h expected %h", r2, e2); end
    checks++; if (bc !== 16)  begin errors++; $display("FAIL b2b_busy_cycles: got %0d expected 16", bc); end
  endtask

  task automatic test_ignore_busy();
    int da, d2a, nd, bc, hb; logic [16:0] r, r2, e;
    launch(1, 16'h00C8, 16'h0064, 1'b0);
    fork
      obs(8, 2, -1, 17'h0, da, d2a, nd, bc, hb, r, r2);
      begin
        @(negedge clk);
        op_a = 16'h0001;
        op_b = 16'h0001;
      end
    join
    e = pop_exp();
    checks++; if (da !== 2) begin errors++; $display("FAIL ign_latency: got %0d expected 2", da); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL ign_done_count: got %0d expected 1", nd); end
    checks++; if (bc !== 2) begin errors++; $display("FAIL ign_busy_cycles: got %0d expected 2", bc); end
    checks++; if (r !== e)  begin errors++; $display("FAIL ign_result: got %h expected %h", r, e); end
    checks++; if ({m_cout, m_sum} !== e) begin errors++; $display("FAIL ign_sum_held: got %h expected %h", {m_cout, m_sum}, e); end
  endtask

  task automatic test_reset_mid_op();
    int da, d2a, nd, bc, hb; logic [16:0] r, r2, e;
    launch(0, 16'h0011, 16'h0022, 1'b0);
    obs(12, 0, -1, 17'h00046, da, d2a, nd, bc, hb, r, r2);
    e = pop_exp();
    checks++; if (r !== e) begin errors++; $display("FAIL rst_first_result: got %h expected %h", r, e); end
    launch(0, 16'h00F0, 16'h000F, 1'b0);
    obs(14, 0, 3, 17'h00033, da, d2a, nd, bc, hb, r, r2);
    void'(exp_q.pop_back());
    checks++; if (nd !== 0) begin errors++; $display("FAIL rst_no_done: got %0d pulses expected 0", nd); end
    checks++; if (bc !== 4) begin errors++; $display("FAIL rst_busy_cycles: got %0d expected 4", bc); end
    checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL rst_busy_after: got %b expected 0", m_busy); end
    checks++; if ({m_cout, m_sum} !== 17'h0) begin errors++; $display("FAIL rst_sum_cleared: got %h expected 00000", {m_cout, m_sum}); end
    launch(0, 16'h000F, 16'h0001, 1'b0);
    obs(12, 0, -1, 17'h0, da, d2a, nd, bc, hb, r, r2);
    e = pop_exp();
    checks++; if (r !== e)  begin errors++; $display("FAIL rst_fresh_result: got %h expected %h", r, e); end
    checks++; if (da !== 8) begin errors++; $display("FAIL rst_fresh_latency: got %0d expected 8", da); end
  endtask

  task automatic test_wide_hold();
    int da, d2a, nd, bc, hb; logic [16:0] r, r2, e;
    launch(2, 16'h1234, 16'h4321, 1'b0);
    obs(20, 0, -1, 17'h0, da, d2a, nd, bc, hb, r, r2);
    e = pop_exp();
    checks++; if (r !== e) begin errors++; $display("FAIL wide_first_result: got %h expected %h", r, e); end
    launch(2, 16'h8000, 16'h8000, 1'b0);
    obs(20, 0, -1, e, da, d2a, nd, bc, hb, r, r2);
    e = pop_exp();
    checks++; if (da !== 16) begin errors++; $display("FAIL wide_latency: got %0d expected 16", da); end
    checks++; if (hb !== 0)  begin errors++; $display("FAIL wide_sum_hold: got %0d bad cycles expected 0", hb); end
    checks++; if (r !== e)   begin errors++; $display("FAIL wide_result: got %h expected %h", r, e); end
  endtask

  task automatic test_sub();
    int da, d2a, nd, bc, hb; logic [16:0] r, r2, e, prev;
    logic [15:0] ta[3];
    logic [15:0] tb[3];
    logic        ts[3];
    ta = '{16'h0010, 16'h0020, 16'h0020};
    tb = '{16'h0020, 16'h0010, 16'h0010};
`ifdef SERIAL_ADDER_SUB_EN
    ts = '{1'b1, 1'b1, 1'b0};
`else
    ts = '{1'b0, 1'b0, 1'b0};
`endif
    prev = 17'h0;
    for (int i = 0; i < 3; i++) begin
      launch(3, ta[i], tb[i], ts[i]);
      obs(8, 0, -1, prev, da, d2a, nd, bc, hb, r, r2);
      e = pop_exp();
      checks++; if (da !== 4) begin errors++; $display("FAIL sub_latency[%0d]: got %0d expected 4", i, da); end
      checks++; if (r !== e)  begin errors++; $display("FAIL sub_result[%0d]: got %h expected %h", i, r, e); end
      prev = e;
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    start_vec = '0;
    rst_vec   = '1;
    op_a      = '0;
    op_b      = '0;
    op_sub    = 1'b0;
    sel       = 0;
    test_reset();
    test_add_basic();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid_op();
    test_wide_hold();
    test_sub();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised, multi-cycle, digit-serial adder. It is the sequential successor to the team's combinational half/full adder cells.
- Adds two WIDTH-bit operands DIGIT bits per clock, using one DIGIT-bit adder slice and a registered carry.
- Uses a start/busy/done handshake.
- Used where area matters more than latency, e.g. accumulators and checksum engines.

Parameters:
WIDTH, 8, operand/result width in bits; must be >= 1
DIGIT, 1, bits added per clock; must divide WIDTH exactly (elaboration error otherwise)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  request; sampled only while idle
a  input  WIDTH  operand A; captured on accepted start
b  input  WIDTH  operand B; captured on accepted start
busy  output  1  high while an addition is in progress
done  output  1  one-cycle pulse; sum/cout valid from this cycle
sum  output  WIDTH  result, registered; holds until next done
cout  output  1  carry out of MSB, registered; holds with sum

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; busy=0, done=0, sum=0, cout=0; internal carry, shift registers and digit counter cleared. Reset has priority over every other event, including mid-operation; a partial result is discarded and never shown on sum.
- N = WIDTH/DIGIT. States:
  - IDLE: busy=0.
  - RUN: busy=1.
  - No separate DONE state; done is a registered pulse.
- IDLE, start=1 at edge E0:
  - latch a and b into shift registers; carry=0; counter=0.
  - go to RUN; busy=1 after E0.
- IDLE, start=0: hold. sum/cout keep their last values.
- RUN, edge E(i+1), i=0..N-1:
  - add the DIGIT LSBs of A, the DIGIT LSBs of B and carry.
  - shift the DIGIT-bit result into the result register from the MSB side.
  - update carry; shift operands right by DIGIT; increment counter.
- At edge EN (last digit):
  - sum <= full result; cout <= final carry.
  - done <= 1; busy <= 0; state <= IDLE.
- Latency: done is high in the cycle following edge EN, i.e. N clocks after the accepted start edge.
- done returns to 0 at edge EN+1. Throughput is one addition per N+1 clocks.
- start while busy=1, including at edge EN: ignored, never queued. Operands change while busy: no effect.
- start asserted continuously: a new operation is accepted at EN+1, the first edge with state=IDLE.
- sum/cout are stable except at a done edge or reset; they are never driven with intermediate values.
- Arithmetic: sum = (a+b) mod 2^WIDTH; cout = bit WIDTH of a+b. Unsigned; no overflow flag.
- DIGIT=WIDTH is legal: N=1, done follows start by one clock.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN
- Defined:
  - adds input port sub (1 bit), captured with a and b on an accepted start.
  - sub=1: computes a-b as a + ~b + 1 (inverted B, initial carry=1). sum = (a-b) mod 2^WIDTH; cout=1 means no borrow (a>=b).
  - sub=0: identical to addition.
- Not defined: the sub port does not exist; addition only; initial carry always 0.

Test Plan:
- WIDTH=8, DIGIT=1, reset then start with a=0x5A, b=0x3C -> busy high for 8 clocks; done pulses exactly once, 8 clocks after the start edge; sum=0x96, cout=0.
- WIDTH=8, DIGIT=1, a=0xFF, b=0x01 -> sum=0x00, cout=1. Follow with start held high throughout -> second operation accepted exactly 9 clocks after the first start (one idle edge between ops).
- WIDTH=8, DIGIT=4, a=0xC8, b=0x64 -> done 2 clocks after start; sum=0x2C, cout=1. Pulse start with a=0x01, b=0x01 at clock 1 (busy) -> ignored; sum stays 0x2C, only one done.
- WIDTH=8, DIGIT=1: first op a=0x11, b=0x22 completes (sum=0x33). Second op a=0xF0, b=0x0F; assert rst at clock 4 -> busy=0, done never pulses, sum=0x00, cout=0. A fresh start afterwards with a=0x0F, b=0x01 -> sum=0x10, cout=0.
- WIDTH=16, DIGIT=1, a=0x8000, b=0x8000 -> done after 16 clocks; sum=0x0000, cout=1. sum must read the previous value on every clock before done.
- With SERIAL_ADDER_SUB_EN defined, WIDTH=8, DIGIT=2, sub=1:
  - a=0x10, b=0x20 -> sum=0xF0, cout=0.
  - a=0x20, b=0x10 -> sum=0x10, cout=1.
  - sub=0, a=0x20, b=0x10 -> sum=0x30.
